// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_ctrl
// Description : Data-memory access sequencer for the EX/MEM instruction over
//               a req/ack bus: lane steering, load extension, misalign/timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_dmen,
    input  logic        mem_memwr,
    input  logic [1:0]  mem_dm_type,
    input  logic        mem_dm_extsigned,
    input  logic [31:0] mem_result,
    input  logic [31:0] mem_rt,
    input  logic        flush_i,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        stall_o,
    output logic [31:0] mem_rdata_o,
    output logic        align_exc_o,
    output logic        dm_fault_o,
    output logic [31:0] badvaddr_o
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        type_q, type_d;
    logic              ext_q, ext_d;
    logic [1:0]        lo_q, lo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       badv_q, badv_d;
    logic              align_q, align_d;
    logic              fault_q, fault_d;
    logic              w_stall;

    logic              w_misaligned;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;
    logic              w_cnt_last;

    always_comb begin
        w_misaligned = 1'b0;
        w_be         = 4'b1111;
        w_wdata      = mem_rt;
        case (mem_dm_type)
            2'b00: begin
                w_be    = 4'b0001 << mem_result[1:0];
                w_wdata = {4{mem_rt[7:0]}};
            end
            2'b01: begin
                w_misaligned = mem_result[0];
                w_be         = mem_result[1] ? 4'b1100 : 4'b0011;
                w_wdata      = {2{mem_rt[15:0]}};
            end
            default: begin
                w_misaligned = (mem_result[1:0] != 2'b00);
            end
        endcase
    end

    // Load lane/extension uses the attributes latched at issue, not the live EX/MEM bus.
    always_comb begin
        w_byte = bus_rdata[{lo_q, 3'b000} +: 8];
        w_half = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (type_q)
            2'b00:   w_load = ext_q ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
            2'b01:   w_load = ext_q ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
            default: w_load = bus_rdata;
        endcase
    end

    assign w_cnt_last = (cnt_q == C_CNT_LAST);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        type_d  = type_q;
        ext_d   = ext_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        badv_d  = badv_q;
        align_d = 1'b0;
        fault_d = 1'b0;
        w_stall = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_dmen && !flush_i) begin
                    if (w_misaligned) begin
                        align_d = 1'b1;
                        badv_d  = mem_result;
                    end else begin
                        w_stall = 1'b1;
                        req_d   = 1'b1;
                        we_d    = mem_memwr;
                        addr_d  = {mem_result[31:2], 2'b00};
                        lo_d    = mem_result[1:0];
                        be_d    = w_be;
                        wdata_d = w_wdata;
                        type_d  = mem_dm_type;
                        ext_d   = mem_dm_extsigned;
                        cnt_d   = '0;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                w_stall = 1'b1;
                if (bus_ack) begin
                    req_d = 1'b0;
                    if (flush_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        if (!we_q) rdata_d = w_load;
                        state_d = ST_DONE;
                    end
                end else if (w_cnt_last) begin
                    req_d = 1'b0;
                    if (flush_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        fault_d = 1'b1;
                        badv_d  = addr_q;
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (flush_i) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Transfer already on the bus: let it finish, then discard it silently.
                w_stall = 1'b1;
                if (bus_ack || w_cnt_last) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            type_q  <= '0;
            ext_q   <= 1'b0;
            lo_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            badv_q  <= '0;
            align_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            type_q  <= type_d;
            ext_q   <= ext_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            badv_q  <= badv_d;
            align_q <= align_d;
            fault_q <= fault_d;
        end
    end

    // Stall is combinational from EX/MEM inputs, so mask it while reset is held.
    assign stall_o     = w_stall & reset_n;
    assign bus_req     = req_q;
    assign bus_we      = we_q;
    assign bus_addr    = addr_q;
    assign bus_be      = be_q;
    assign bus_wdata   = wdata_q;
    assign mem_rdata_o = rdata_q;
    assign align_exc_o = align_q;
    assign dm_fault_o  = fault_q;
    assign badvaddr_o  = badv_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_access_ctrl
// Description : Directed self-checking bench for dmem_access_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_dmen;
    logic        mem_memwr;
    logic [1:0]  mem_dm_type;
    logic        mem_dm_extsigned;
    logic [31:0] mem_result;
    logic [31:0] mem_rt;
    logic        flush_i;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        stall_o;
    logic [31:0] mem_rdata_o;
    logic        align_exc_o;
    logic        dm_fault_o;
    logic [31:0] badvaddr_o;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;
    logic        cap_we;
    int          nst;
    int          nf;

    dmem_access_ctrl #(.TIMEOUT(256), .CNT_W(9)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .mem_dmen         (mem_dmen),
        .mem_memwr        (mem_memwr),
        .mem_dm_type      (mem_dm_type),
        .mem_dm_extsigned (mem_dm_extsigned),
        .mem_result       (mem_result),
        .mem_rt           (mem_rt),
        .flush_i          (flush_i),
        .bus_req          (bus_req),
        .bus_we           (bus_we),
        .bus_addr         (bus_addr),
        .bus_be           (bus_be),
        .bus_wdata        (bus_wdata),
        .bus_rdata        (bus_rdata),
        .bus_ack          (bus_ack),
        .stall_o          (stall_o),
        .mem_rdata_o      (mem_rdata_o),
        .align_exc_o      (align_exc_o),
        .dm_fault_o       (dm_fault_o),
        .badvaddr_o       (badvaddr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] ty, input logic ext,
                         input logic [31:0] addr, input logic [31:0] rt);
        @(negedge clk);
        mem_dmen         = 1'b1;
        mem_memwr        = we;
        mem_dm_type      = ty;
        mem_dm_extsigned = ext;
        mem_result       = addr;
        mem_rt           = rt;
        bus_ack          = 1'b0;
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        mem_dmen = 1'b0;
        flush_i  = 1'b0;
        bus_ack  = 1'b0;
        #1;
    endtask

    // Runs a stalled access to completion; the slave acks on the (wait_n+1)-th req cycle.
    task automatic run_access(input int wait_n, input logic [31:0] rd,
                              output int n_stall, output int n_fault);
        int  reqc;
        bit  got;
        n_stall = 0;
        n_fault = 0;
        reqc    = 0;
        got     = 1'b0;
        while (stall_o && n_stall < 1000) begin
            n_stall++;
            @(negedge clk);
            if (bus_req) begin
                reqc++;
                if (!got) begin
                    cap_addr  = bus_addr;
                    cap_be    = bus_be;
                    cap_wdata = bus_wdata;
                    cap_we    = bus_we;
                    got       = 1'b1;
                end
            end
            bus_ack   = bus_req && (reqc == wait_n + 1);
            bus_rdata = rd;
            #1;
            if (dm_fault_o) n_fault++;
        end
        chk("access_bound", 32'(n_stall < 1000), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; mem_dmen = 1'b0; mem_memwr = 1'b0; mem_dm_type = 2'b00;
        mem_dm_extsigned = 1'b0; mem_result = '0; mem_rt = '0; flush_i = 1'b0;
        bus_rdata = '0; bus_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req",   32'(bus_req), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_addr",  bus_addr, 32'd0);
        chk("rst_be",    32'(bus_be), 32'd0);
        chk("rst_rdata", mem_rdata_o, 32'd0);
        chk("rst_badv",  badvaddr_o, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Signed byte load, lane 3, ack on third req cycle
        issue(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'd0);
        chk("t1_stall0", 32'(stall_o), 32'd1);
        run_access(2, 32'h80FF_FF12, nst, nf);
        chk("t1_be",     32'(cap_be), 32'h8);
        chk("t1_addr",   cap_addr, 32'h0000_1000);
        chk("t1_we",     32'(cap_we), 32'd0);
        chk("t1_nstall", 32'(nst), 32'd4);
        chk("t1_done",   32'(stall_o), 32'd0);
        chk("t1_req",    32'(bus_req), 32'd0);
        chk("t1_rdata",  mem_rdata_o, 32'hFFFF_FF80);
        idle();
        chk("t1_noreiss", 32'(bus_req), 32'd0);

        // Half store
        issue(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD);
        run_access(1, 32'hFFFF_FFFF, nst, nf);
        chk("t2_we",    32'(cap_we), 32'd1);
        chk("t2_be",    32'(cap_be), 32'hC);
        chk("t2_wdata", cap_wdata, 32'hABCD_ABCD);
        chk("t2_addr",  cap_addr, 32'h0000_2000);
        chk("t2_rdata", mem_rdata_o, 32'hFFFF_FF80);

        // Zero-extended half load, upper lane
        issue(1'b0, 2'b01, 1'b0, 32'h0000_7002, 32'd0);
        run_access(0, 32'h8123_4567, nst, nf);
        chk("t3_be",    32'(cap_be), 32'hC);
        chk("t3_rdata", mem_rdata_o, 32'h0000_8123);
        chk("t3_nstall", 32'(nst), 32'd2);

        // Word load, unmodified
        issue(1'b0, 2'b10, 1'b1, 32'h0000_7000, 32'd0);
        run_access(1, 32'hDEAD_BEEF, nst, nf);
        chk("t4_be",    32'(cap_be), 32'hF);
        chk("t4_rdata", mem_rdata_o, 32'hDEAD_BEEF);

        // Byte store, lane 1
        issue(1'b1, 2'b00, 1'b0, 32'h0000_8001, 32'h1234_5678);
        run_access(0, 32'd0, nst, nf);
        chk("t5_be",    32'(cap_be), 32'h2);
        chk("t5_wdata", cap_wdata, 32'h7878_7878);
        idle();

        // Misaligned word load
        issue(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'd0);
        chk("t6_stall", 32'(stall_o), 32'd0);
        idle();
        chk("t6_align", 32'(align_exc_o), 32'd1);
        chk("t6_badv",  badvaddr_o, 32'h0000_3001);
        chk("t6_req",   32'(bus_req), 32'd0);
        idle();
        chk("t6_pulse", 32'(align_exc_o), 32'd0);

        // Misaligned half load
        issue(1'b0, 2'b01, 1'b0, 32'h0000_3005, 32'd0);
        chk("t6h_stall", 32'(stall_o), 32'd0);
        idle();
        chk("t6h_align", 32'(align_exc_o), 32'd1);
        chk("t6h_badv",  badvaddr_o, 32'h0000_3005);

        // Timeout: no ack at all
        issue(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'd0);
        run_access(100000, 32'd0, nst, nf);
        chk("t7_nstall", 32'(nst), 32'd257);
        chk("t7_fault",  32'(nf), 32'd1);
        chk("t7_req",    32'(bus_req), 32'd0);
        chk("t7_badv",   badvaddr_o, 32'h0000_4000);
        chk("t7_rdata",  mem_rdata_o, 32'hDEAD_BEEF);
        idle();
        chk("t7_pulse",  32'(dm_fault_o), 32'd0);

        // Ack in the same cycle the counter reaches its limit
        issue(1'b0, 2'b10, 1'b0, 32'h0000_4800, 32'd0);
        run_access(255, 32'h1357_9BDF, nst, nf);
        chk("t8_nstall", 32'(nst), 32'd257);
        chk("t8_fault",  32'(nf), 32'd0);
        chk("t8_rdata",  mem_rdata_o, 32'h1357_9BDF);
        idle();

        // Flush while BUSY, ack three cycles later
        issue(1'b0, 2'b00, 1'b0, 32'h0000_5000, 32'd0);
        @(negedge clk); flush_i = 1'b1; mem_dmen = 1'b0; #1;
        chk("t9_req1",   32'(bus_req), 32'd1);
        @(negedge clk); flush_i = 1'b0; #1;
        chk("t9_drain",  32'(stall_o), 32'd1);
        chk("t9_req2",   32'(bus_req), 32'd1);
        @(negedge clk); #1;
        @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'hAAAA_AA55; #1;
        chk("t9_stall",  32'(stall_o), 32'd1);
        @(negedge clk); bus_ack = 1'b0; #1;
        chk("t9_idle",   32'(stall_o), 32'd0);
        chk("t9_reqoff", 32'(bus_req), 32'd0);
        chk("t9_rdata",  mem_rdata_o, 32'h1357_9BDF);
        chk("t9_fault",  32'(dm_fault_o), 32'd0);

        // Reset asserted mid-access, dmen held high through it
        issue(1'b1, 2'b10, 1'b0, 32'h0000_6000, 32'hCAFE_F00D);
        @(negedge clk); #1;
        chk("t10_req",   32'(bus_req), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t10_rreq",  32'(bus_req), 32'd0);
        chk("t10_rstl",  32'(stall_o), 32'd0);
        @(negedge clk); #1;
        chk("t10_raddr", bus_addr, 32'd0);
        @(negedge clk); reset_n = 1'b1; #1;
        chk("t10_stall", 32'(stall_o), 32'd1);
        run_access(0, 32'd0, nst, nf);
        chk("t10_addr",  cap_addr, 32'h0000_6000);
        chk("t10_we",    32'(cap_we), 32'd1);
        chk("t10_wdata", cap_wdata, 32'hCAFE_F00D);
        chk("t10_nst",   32'(nst), 32'd2);
        chk("t10_rdata", mem_rdata_o, 32'd0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
